path_read_unpacker: RTL and testbench
=====================================

Name: path_read_unpacker

Overview:
- Sits on the DRAM read-return path, directly downstream of the DRAM read-data interface and upstream of the stash.
- Buffers raw DRAMReadData beats for one ORAM path read issued by the backend address generator, parses each bucket's header, and discards dummy blocks.
- Emits real blocks to the stash as StashDWidth-wide chunks, tagged with PAddr and Leaf, under a valid/ready handshake.

Parameters:
- ORAMB, 512, block data bits.
- ORAMU, 32, PAddr width.
- ORAML, 15, leaf width; path has ORAML+1 buckets.
- ORAMZ, 5, blocks per bucket.
- DDRDWidth, 512, DRAM read beat width.
- StashDWidth, 64, output chunk width; must divide DDRDWidth and ORAMB.
- FIFODepth, 128, beat buffer depth; must be >= one path (96 at defaults).

Ports:
- Clock, in, 1, sole clock.
- Reset, in, 1, synchronous, active-high.
- PathStart, in, 1, request to parse one path.
- PathStartReady, out, 1, high only in ST_Idle.
- DRAMReadData, in, DDRDWidth, read beat.
- DRAMReadDataValid, in, 1, beat strobe; no backpressure.
- OutData, out, StashDWidth, block chunk.
- OutPAddr, out, ORAMU, PAddr of current block.
- OutLeaf, out, ORAML, leaf of current block.
- OutValid, out, 1, chunk valid.
- OutReady, in, 1, stash accepts chunk.
- BlockComplete, out, 1, pulse with last chunk handshake of a block.
- PathComplete, out, 1, pulse when path fully consumed.
- Overflow, out, 1, sticky beat-drop error.

Behaviour:
- Reset: all outputs 0; FIFO flushed; counters 0; state ST_Idle; Overflow cleared. Reset mid-path abandons the path; no partial completion pulses.
- Derived constants:
  - HdrBeats = ceil(Z*(1+U+L)/DDRDWidth) (1 at defaults).
  - BlkBeats = B/DDRDWidth (1).
  - ChunksPerBeat = DDRDWidth/StashDWidth (8).
  - BucketBeats = HdrBeats + Z*BlkBeats (6).
- FIFO write: every cycle with DRAMReadDataValid, in any state. If the FIFO is full, the beat is dropped and Overflow sets and stays set until Reset.
- Header layout, LSB first:
  - valid bits at [Z-1:0];
  - PAddr i at [Z+i*U +: U];
  - Leaf i at [Z+Z*U+i*L +: L];
  - remainder is don't-care.
- States:
  - ST_Idle: PathStartReady=1. PathStart → ST_Header; BucketCnt=0.
  - ST_Header: pop HdrBeats beats into the header register; BlockCnt=0 → ST_Block.
  - ST_Block: if valid[BlockCnt]=0, pop and discard BlkBeats beats at 1 beat/cycle with no output. Otherwise load each beat into a shift register and present chunks, least-significant StashDWidth first.
    - OutValid is held with OutData/OutPAddr/OutLeaf stable until OutReady.
    - Throughput is 1 chunk/cycle while OutReady=1.
    - The next beat pops no earlier than the cycle its predecessor's last chunk handshakes; a one-cycle bubble between beats is allowed.
    - BlockComplete pulses in the handshake cycle of the final chunk.
    - After the last block: if BucketCnt==ORAML → ST_Done, else BucketCnt++ → ST_Header.
  - ST_Done: PathComplete=1 for one cycle → ST_Idle.
- FIFO empty while parsing: stall (no pop, OutValid=0), with no timeout.
- Beats arriving before PathStart are retained and consumed by the next path.
- Counter widths: BucketCnt is clog2(ORAML+1) bits; BlockCnt is clog2(Z) bits; ChunkCnt is clog2(ChunksPerBeat) bits. None wrap beyond their terminal value.
- Latency: a header beat written at cycle t yields the first real chunk with OutValid no earlier than t+2 and, with OutReady=1 and no earlier blocks pending, no later than t+4.

Decomposition:
- Shared package (ORAM constants header): derived HdrBeats, BlkBeats, ChunksPerBeat, BucketBeats, and header field offset functions. These are shared with the future write-path packer.
- Sub-module fifo_ram: single-clock, DDRDWidth x FIFODepth, with registered read, Full, Empty, and synchronous reset flush.
- Header parse, counters and chunk shifter live in the top.

Test Plan:
- Beat counts below are at default parameters.
- All-dummy path: PathStart, then 96 beats with all header valid bits 0 → OutValid never asserts; exactly one PathComplete after the 96th beat is popped; PathStartReady returns to 1.
- Single real block: bucket 0 header valid=5'b00100, PAddr2=0x1234, Leaf2=0x0ABC; block-2 beat = incrementing 64-bit words 0..7; OutReady=1 → 8 chunks 0..7 in order, all tagged 0x1234/0x0ABC; BlockComplete on the 8th handshake only.
- Backpressure: same stimulus with OutReady toggling 1,0,0,1 → no chunk lost or duplicated, outputs stable while OutValid&~OutReady; 8 handshakes total.
- Overflow: OutReady=0, all blocks valid, 129 beats written without pops → Overflow=1 from the 129th beat and held; only Reset clears it.
- Reset mid-path: assert Reset after the 40th beat → all outputs 0 next cycle, FIFO empty; a following clean path parses correctly.
- Back-to-back paths: PathStart again in the cycle after PathComplete, with 192 beats streamed continuously → two PathComplete pulses and correct chunk streams for both paths.

Source files
------------

// File: rtl/path_read_unpacker_pkg.sv
// Shared ORAM geometry helpers: derived beat counts and bucket-header field offsets.
// Shared by the read-path unpacker and the write-path packer.
package path_read_unpacker_pkg;

  typedef int unsigned uint_t;

  typedef enum logic [1:0] {
    ST_Idle,
    ST_Header,
    ST_Block,
    ST_Done
  } state_t;

  function automatic uint_t hdr_beats(input uint_t z, input uint_t u, input uint_t l,
                                      input uint_t w);
    return (z * (1 + u + l) + w - 1) / w;
  endfunction

  function automatic uint_t blk_beats(input uint_t b, input uint_t w);
    return b / w;
  endfunction

  function automatic uint_t chunks_per_beat(input uint_t w, input uint_t s);
    return w / s;
  endfunction

  function automatic uint_t bucket_beats(input uint_t z, input uint_t u, input uint_t l,
                                         input uint_t b, input uint_t w);
    return hdr_beats(z, u, l, w) + z * blk_beats(b, w);
  endfunction

  // Header layout, LSB first: valid[Z-1:0], then Z PAddrs, then Z Leaves.
  function automatic uint_t paddr_off(input uint_t z, input uint_t u, input uint_t i);
    return z + i * u;
  endfunction

  function automatic uint_t leaf_off(input uint_t z, input uint_t u, input uint_t l,
                                     input uint_t i);
    return z + z * u + i * l;
  endfunction

endpackage

// File: rtl/path_read_unpacker_fifo_ram.sv
// Single-clock beat buffer with registered read port; a full FIFO ignores writes.
module path_read_unpacker_fifo_ram #(
  parameter int unsigned W     = 512,
  parameter int unsigned DEPTH = 128
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_wr_en,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_rd_en,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      o_rd_data <= '0;
    end else begin
      if (w_wr) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_rd) begin
        o_rd_data <= r_mem[r_rptr];
        r_rptr    <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      end
      if (w_wr && !w_rd)      r_count <= r_count + 1'b1;
      else if (!w_wr && w_rd) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/path_read_unpacker.sv
// Parses one ORAM path of DRAM read beats: decodes bucket headers, drops dummy
// blocks and streams real blocks to the stash as tagged StashDWidth chunks.
module path_read_unpacker
  import path_read_unpacker_pkg::*;
#(
  parameter int unsigned ORAMB       = 512,
  parameter int unsigned ORAMU       = 32,
  parameter int unsigned ORAML       = 15,
  parameter int unsigned ORAMZ       = 5,
  parameter int unsigned DDRDWidth   = 512,
  parameter int unsigned StashDWidth = 64,
  parameter int unsigned FIFODepth   = 128
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_PathStart,
  output logic                   o_PathStartReady,
  input  logic [DDRDWidth-1:0]   i_DRAMReadData,
  input  logic                   i_DRAMReadDataValid,
  output logic [StashDWidth-1:0] o_OutData,
  output logic [ORAMU-1:0]       o_OutPAddr,
  output logic [ORAML-1:0]       o_OutLeaf,
  output logic                   o_OutValid,
  input  logic                   i_OutReady,
  output logic                   o_BlockComplete,
  output logic                   o_PathComplete,
  output logic                   o_Overflow
);
  localparam uint_t HDR_BEATS = hdr_beats(ORAMZ, ORAMU, ORAML, DDRDWidth);
  localparam uint_t BLK_BEATS = blk_beats(ORAMB, DDRDWidth);
  localparam uint_t CPB       = chunks_per_beat(DDRDWidth, StashDWidth);
  localparam uint_t HDR_W     = HDR_BEATS * DDRDWidth;
  localparam uint_t BKT_W     = $clog2(ORAML + 1);
  localparam uint_t BLK_W     = (ORAMZ > 1) ? $clog2(ORAMZ) : 1;
  localparam uint_t CHK_W     = (CPB > 1) ? $clog2(CPB) : 1;
  localparam uint_t HCNT_W    = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;
  localparam uint_t BB_W      = $clog2(BLK_BEATS + 1);
  localparam logic [BKT_W-1:0] LAST_BKT = BKT_W'(ORAML);

  state_t              r_state, w_state_nxt;
  logic [BKT_W-1:0]    r_bucket;
  logic [BLK_W-1:0]    r_blk;
  logic [CHK_W-1:0]    r_chunk;
  logic [HCNT_W-1:0]   r_hcnt;
  logic [BB_W-1:0]     r_bbeat;
  logic [HDR_W-1:0]    r_hdr;
  logic [DDRDWidth-1:0] r_sh;
  logic                r_sh_vld;
  logic                r_stg_vld;
  logic                r_overflow;

  logic [DDRDWidth-1:0] w_fifo_data;
  logic w_full, w_empty, w_pop, w_consume, w_parsing, w_in_block;
  logic w_hs, w_last_chunk, w_sh_free, w_all_loaded, w_blk_real;
  logic w_load, w_discard, w_hdr_take, w_hcnt_last, w_blk_last, w_blk_done, w_real_done;

  path_read_unpacker_fifo_ram #(
    .W    (DDRDWidth),
    .DEPTH(FIFODepth)
  ) u_fifo (
    .i_clk    (i_Clock),
    .i_rst    (i_Reset),
    .i_wr_en  (i_DRAMReadDataValid),
    .i_wr_data(i_DRAMReadData),
    .i_rd_en  (w_pop),
    .o_rd_data(w_fifo_data),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // The FIFO's registered read port acts as a one-beat staging slot (r_stg_vld);
  // it is refilled in the same cycle it is consumed to sustain 1 beat/cycle.
  assign w_parsing    = (r_state == ST_Header) || (r_state == ST_Block);
  assign w_in_block   = (r_state == ST_Block);
  assign w_blk_real   = r_hdr[r_blk];
  assign w_hs         = r_sh_vld & i_OutReady;
  assign w_last_chunk = (r_chunk == CHK_W'(CPB - 1));
  assign w_sh_free    = ~r_sh_vld | (w_hs & w_last_chunk);
  assign w_all_loaded = (r_bbeat == BB_W'(BLK_BEATS));
  assign w_load       = w_in_block & w_blk_real & r_stg_vld & w_sh_free & ~w_all_loaded;
  assign w_discard    = w_in_block & ~w_blk_real & r_stg_vld;
  assign w_hdr_take   = (r_state == ST_Header) & r_stg_vld;
  assign w_consume    = w_load | w_discard | w_hdr_take;
  assign w_pop        = w_parsing & ~w_empty & (~r_stg_vld | w_consume);
  assign w_hcnt_last  = (r_hcnt == HCNT_W'(HDR_BEATS - 1));
  assign w_blk_last   = (r_blk == BLK_W'(ORAMZ - 1));
  assign w_real_done  = w_in_block & w_blk_real & w_hs & w_last_chunk & w_all_loaded;
  assign w_blk_done   = w_real_done |
                        (w_discard & (r_bbeat == BB_W'(BLK_BEATS - 1)));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_Idle:   if (i_PathStart) w_state_nxt = ST_Header;
      ST_Header: if (w_hdr_take && w_hcnt_last) w_state_nxt = ST_Block;
      ST_Block:  if (w_blk_done && w_blk_last)
                   w_state_nxt = (r_bucket == LAST_BKT) ? ST_Done : ST_Header;
      ST_Done:   w_state_nxt = ST_Idle;
      default:   w_state_nxt = ST_Idle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state    <= ST_Idle;
      r_bucket   <= '0;
      r_blk      <= '0;
      r_chunk    <= '0;
      r_hcnt     <= '0;
      r_bbeat    <= '0;
      r_hdr      <= '0;
      r_sh       <= '0;
      r_sh_vld   <= 1'b0;
      r_stg_vld  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_overflow <= r_overflow | (i_DRAMReadDataValid & w_full);

      if (w_pop)          r_stg_vld <= 1'b1;
      else if (w_consume) r_stg_vld <= 1'b0;

      if (r_state == ST_Idle && i_PathStart) begin
        r_bucket <= '0;
        r_hcnt   <= '0;
      end

      if (w_hdr_take) begin
        r_hdr[uint_t'(r_hcnt) * DDRDWidth +: DDRDWidth] <= w_fifo_data;
        r_hcnt <= w_hcnt_last ? '0 : r_hcnt + 1'b1;
        if (w_hcnt_last) begin
          r_blk   <= '0;
          r_bbeat <= '0;
        end
      end

      if (w_load) begin
        r_sh     <= w_fifo_data;
        r_sh_vld <= 1'b1;
        r_chunk  <= '0;
        r_bbeat  <= r_bbeat + 1'b1;
      end else if (w_hs) begin
        r_sh    <= r_sh >> StashDWidth;
        r_chunk <= w_last_chunk ? '0 : r_chunk + 1'b1;
        if (w_last_chunk) r_sh_vld <= 1'b0;
      end

      if (w_discard) r_bbeat <= r_bbeat + 1'b1;

      if (w_blk_done) begin
        r_bbeat <= '0;
        if (w_blk_last) begin
          r_blk <= '0;
          if (r_bucket != LAST_BKT) begin
            r_bucket <= r_bucket + 1'b1;
            r_hcnt   <= '0;
          end
        end else begin
          r_blk <= r_blk + 1'b1;
        end
      end
    end
  end

  assign o_PathStartReady = (r_state == ST_Idle) & ~i_Reset;
  assign o_OutValid       = r_sh_vld;
  assign o_OutData        = r_sh[StashDWidth-1:0];
  assign o_OutPAddr       = r_sh_vld ? r_hdr[paddr_off(ORAMZ, ORAMU, uint_t'(r_blk)) +: ORAMU] : '0;
  assign o_OutLeaf        = r_sh_vld ? r_hdr[leaf_off(ORAMZ, ORAMU, ORAML, uint_t'(r_blk)) +: ORAML] : '0;
  assign o_BlockComplete  = w_real_done;
  assign o_PathComplete   = (r_state == ST_Done);
  assign o_Overflow       = r_overflow;

endmodule

// File: tb/tb_path_read_unpacker.sv
// Randomized bench for path_read_unpacker against a path-level reference model.
module tb_path_read_unpacker;
  localparam int Z = 5, U = 32, L = 15, NB = L + 1, DW = 512, SW = 64, CPB = DW / SW;

  logic          clk = 1'b0;
  logic          rst;
  logic          path_start;
  logic          ps_ready;
  logic [DW-1:0] rd_data;
  logic          rd_vld;
  logic [SW-1:0] out_data;
  logic [U-1:0]  out_pa;
  logic [L-1:0]  out_pl;
  logic          out_vld, out_rdy, blk_cmp, path_cmp, ovf;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  path_read_unpacker #(
    .ORAMB(512), .ORAMU(U), .ORAML(L), .ORAMZ(Z),
    .DDRDWidth(DW), .StashDWidth(SW), .FIFODepth(128)
  ) dut (
    .i_Clock(clk), .i_Reset(rst), .i_PathStart(path_start), .o_PathStartReady(ps_ready),
    .i_DRAMReadData(rd_data), .i_DRAMReadDataValid(rd_vld),
    .o_OutData(out_data), .o_OutPAddr(out_pa), .o_OutLeaf(out_pl), .o_OutValid(out_vld),
    .i_OutReady(out_rdy), .o_BlockComplete(blk_cmp), .o_PathComplete(path_cmp),
    .o_Overflow(ovf)
  );

  // Path description and the model's expected chunk stream
  bit            pv   [NB][Z];
  logic [U-1:0]  pa   [NB][Z];
  logic [L-1:0]  pl   [NB][Z];
  logic [DW-1:0] pdat [NB][Z];
  logic [DW-1:0] beat_q[$];
  logic [SW-1:0] exp_d[$], obs_d[$];
  logic [U-1:0]  exp_pa[$], obs_pa[$];
  logic [L-1:0]  exp_pl[$], obs_pl[$];
  bit            exp_bc[$], obs_bc[$];
  int pc_cnt, stab_err, bc_err;
  bit valid_seen, timed_out;

  function automatic logic [DW-1:0] rand_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic clear_queues();
    beat_q.delete();
    exp_d.delete(); exp_pa.delete(); exp_pl.delete(); exp_bc.delete();
  endtask

  task automatic randomize_path(input int n_real);
    for (int b = 0; b < NB; b++)
      for (int i = 0; i < Z; i++) begin
        pv[b][i]   = 1'b0;
        pa[b][i]   = $urandom();
        pl[b][i]   = L'($urandom());
        pdat[b][i] = rand_beat();
      end
    repeat (n_real) pv[$urandom_range(NB - 1)][$urandom_range(Z - 1)] = 1'b1;
  endtask

  // Model: one header beat per bucket then Z block beats; real blocks yield CPB chunks LSB-first.
  task automatic emit_path();
    logic [DW-1:0] h;
    for (int b = 0; b < NB; b++) begin
      h = rand_beat();
      for (int i = 0; i < Z; i++) begin
        h[i]                 = pv[b][i];
        h[Z + i*U +: U]      = pa[b][i];
        h[Z + Z*U + i*L +: L] = pl[b][i];
      end
      beat_q.push_back(h);
      for (int i = 0; i < Z; i++) begin
        beat_q.push_back(pdat[b][i]);
        if (pv[b][i])
          for (int k = 0; k < CPB; k++) begin
            exp_d.push_back(pdat[b][i][k*SW +: SW]);
            exp_pa.push_back(pa[b][i]);
            exp_pl.push_back(pl[b][i]);
            exp_bc.push_back(k == CPB - 1);
          end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; path_start = 1'b0; rd_vld = 1'b0; rd_data = '0; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drive_beats(input int gap_pct);
    while (beat_q.size() > 0) begin
      @(posedge clk); #1;
      if ($urandom_range(99) < gap_pct) rd_vld = 1'b0;
      else begin
        rd_data = beat_q.pop_front();
        rd_vld  = 1'b1;
      end
    end
    @(posedge clk); #1 rd_vld = 1'b0;
  endtask

  // Records handshakes and protocol events; mode 0: ready=1, 1: pattern 1,0,0,1, 2: random
  task automatic collect(input int n_paths, input int mode, input int max_cycles);
    int cyc = 0, tail = 0, starts_left = n_paths;
    logic pv_q = 1'b0, pr_q = 1'b0;
    logic [SW-1:0] pd_q = '0;
    logic [U-1:0]  ppa_q = '0;
    logic [L-1:0]  ppl_q = '0;
    logic [3:0]    pat = 4'b1001;
    obs_d.delete(); obs_pa.delete(); obs_pl.delete(); obs_bc.delete();
    pc_cnt = 0; stab_err = 0; bc_err = 0; valid_seen = 1'b0;
    while (cyc < max_cycles && tail < 10) begin
      @(posedge clk); #1;
      path_start = (starts_left > 0);
      case (mode)
        0:       out_rdy = 1'b1;
        1:       out_rdy = pat[cyc % 4];
        default: out_rdy = ($urandom_range(1) == 1);
      endcase
      @(negedge clk);
      cyc++;
      if (path_start && ps_ready) starts_left--;
      if (pv_q && !pr_q && (!out_vld || out_data !== pd_q || out_pa !== ppa_q || out_pl !== ppl_q))
        stab_err++;
      if (out_vld) valid_seen = 1'b1;
      if (out_vld && out_rdy) begin
        obs_d.push_back(out_data); obs_pa.push_back(out_pa);
        obs_pl.push_back(out_pl); obs_bc.push_back(blk_cmp);
      end else if (blk_cmp) bc_err++;
      if (path_cmp) pc_cnt++;
      if (pc_cnt >= n_paths) tail++;
      pv_q = out_vld; pr_q = out_rdy; pd_q = out_data; ppa_q = out_pa; ppl_q = out_pl;
    end
    timed_out = (pc_cnt < n_paths);
    path_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; path_start = 1'b0; rd_vld = 1'b0; rd_data = '0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ps_ready, out_vld, out_data, out_pa, out_pl, blk_cmp, path_cmp, ovf} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h pc=%b ovf=%b, expected all 0",
               ps_ready, out_vld, out_data, path_cmp, ovf);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ps_ready !== 1'b1 || out_vld !== 1'b0 || ovf !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_idle: rdy=%b vld=%b ovf=%b, expected 1/0/0", ps_ready, out_vld, ovf);
    end
  endtask

  task automatic test_all_dummy();
    do_reset(); clear_queues(); randomize_path(0); emit_path();
    fork
      drive_beats(0);
      collect(1, 0, 1000);
    join
    n_cmp++;
    if (valid_seen !== 1'b0) begin n_mis++; $display("FAIL dummy_no_valid: OutValid seen, expected never"); end
    n_cmp++;
    if (pc_cnt !== 1 || timed_out) begin n_mis++; $display("FAIL dummy_pathcomplete: got %0d pulses, expected 1", pc_cnt); end
    n_cmp++;
    if (ps_ready !== 1'b1) begin n_mis++; $display("FAIL dummy_ready: got %b, expected 1", ps_ready); end
    n_cmp++;
    if (bc_err !== 0) begin n_mis++; $display("FAIL dummy_blockcomplete: got %0d stray pulses, expected 0", bc_err); end
  endtask

  task automatic single_block_stim();
    randomize_path(0);
    pv[0][2] = 1'b1; pa[0][2] = 32'h1234; pl[0][2] = 15'h0ABC;
    for (int k = 0; k < CPB; k++) pdat[0][2][k*SW +: SW] = 64'(k);
    emit_path();
  endtask

  task automatic test_single_block();
    do_reset(); clear_queues(); single_block_stim();
    fork
      drive_beats(0);
      collect(1, 0, 1000);
    join
    n_cmp++;
    if (obs_d.size() !== CPB) begin n_mis++; $display("FAIL single_count: got %0d chunks, expected %0d", obs_d.size(), CPB); end
    for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
      n_cmp++;
      if ({obs_d[k], obs_pa[k], obs_pl[k], obs_bc[k]} !== {exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]}) begin
        n_mis++;
        $display("FAIL single_chunk[%0d]: got %h/%h/%h/%b, expected %h/%h/%h/%b", k, obs_d[k], obs_pa[k],
                 obs_pl[k], obs_bc[k], exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]);
      end
    end
    n_cmp++;
    if (bc_err !== 0 || pc_cnt !== 1) begin n_mis++; $display("FAIL single_events: bc_err=%0d pc=%0d, expected 0/1", bc_err, pc_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset(); clear_queues(); single_block_stim();
    fork
      drive_beats(0);
      collect(1, 1, 1000);
    join
    n_cmp++;
    if (obs_d.size() !== CPB) begin n_mis++; $display("FAIL bp_count: got %0d handshakes, expected %0d", obs_d.size(), CPB); end
    for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
      n_cmp++;
      if ({obs_d[k], obs_bc[k]} !== {exp_d[k], exp_bc[k]}) begin
        n_mis++;
        $display("FAIL bp_chunk[%0d]: got %h/%b, expected %h/%b", k, obs_d[k], obs_bc[k], exp_d[k], exp_bc[k]);
      end
    end
    n_cmp++;
    if (stab_err !== 0) begin n_mis++; $display("FAIL bp_stable: got %0d unstable stalls, expected 0", stab_err); end
  endtask

  task automatic test_random_paths();
    for (int p = 0; p < 3; p++) begin
      do_reset(); clear_queues(); randomize_path(12); emit_path();
      fork
        drive_beats(30);
        collect(1, 2, 5000);
      join
      n_cmp++;
      if (obs_d.size() !== exp_d.size() || timed_out) begin
        n_mis++;
        $display("FAIL rand%0d_count: got %0d chunks, expected %0d (timeout=%b)", p, obs_d.size(), exp_d.size(), timed_out);
      end
      for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
        n_cmp++;
        if ({obs_d[k], obs_pa[k], obs_pl[k], obs_bc[k]} !== {exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]}) begin
          n_mis++;
          $display("FAIL rand%0d_chunk[%0d]: got %h/%h/%h/%b, expected %h/%h/%h/%b", p, k, obs_d[k], obs_pa[k],
                   obs_pl[k], obs_bc[k], exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]);
        end
      end
      n_cmp++;
      if (stab_err !== 0 || bc_err !== 0 || ovf !== 1'b0) begin
        n_mis++;
        $display("FAIL rand%0d_protocol: stab=%0d bc=%0d ovf=%b, expected 0/0/0", p, stab_err, bc_err, ovf);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset(); clear_queues();
    path_start = 1'b0; out_rdy = 1'b0;
    for (int n = 1; n <= 129; n++) begin
      @(posedge clk); #1;
      rd_vld = 1'b1; rd_data = rand_beat();
      if (n == 129) begin
        @(negedge clk);
        n_cmp++;
        if (ovf !== 1'b0) begin n_mis++; $display("FAIL ovf_128: got %b after 128 beats, expected 0", ovf); end
      end
    end
    @(posedge clk); #1 rd_vld = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b1) begin n_mis++; $display("FAIL ovf_129: got %b after 129 beats, expected 1", ovf); end
    path_start = 1'b1; out_rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1 path_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b1) begin n_mis++; $display("FAIL ovf_sticky: got %b, expected 1", ovf); end
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b0) begin n_mis++; $display("FAIL ovf_clear: got %b after reset, expected 0", ovf); end
  endtask

  task automatic test_reset_mid_path();
    do_reset(); clear_queues(); randomize_path(20); emit_path();
    @(posedge clk); #1;
    out_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      path_start = (n == 0);
      rd_vld = 1'b1; rd_data = beat_q.pop_front();
    end
    @(posedge clk); #1;
    rd_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({ps_ready, out_vld, out_data, out_pa, out_pl, blk_cmp, path_cmp, ovf} !== '0) begin
      n_mis++;
      $display("FAIL midrst_outputs: got rdy=%b vld=%b data=%h pa=%h pc=%b, expected all 0",
               ps_ready, out_vld, out_data, out_pa, path_cmp);
    end
    rst = 1'b0;
    clear_queues(); randomize_path(8); emit_path();
    fork
      drive_beats(10);
      collect(1, 2, 5000);
    join
    n_cmp++;
    if (obs_d.size() !== exp_d.size() || pc_cnt !== 1) begin
      n_mis++;
      $display("FAIL midrst_clean: got %0d chunks/%0d paths, expected %0d/1", obs_d.size(), pc_cnt, exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
      n_cmp++;
      if ({obs_d[k], obs_pa[k], obs_pl[k]} !== {exp_d[k], exp_pa[k], exp_pl[k]}) begin
        n_mis++;
        $display("FAIL midrst_chunk[%0d]: got %h/%h/%h, expected %h/%h/%h", k, obs_d[k], obs_pa[k], obs_pl[k],
                 exp_d[k], exp_pa[k], exp_pl[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); clear_queues();
    randomize_path(3); emit_path();
    randomize_path(3); emit_path();
    fork
      drive_beats(0);
      collect(2, 0, 4000);
    join
    n_cmp++;
    if (pc_cnt !== 2 || timed_out) begin n_mis++; $display("FAIL b2b_paths: got %0d PathComplete, expected 2", pc_cnt); end
    n_cmp++;
    if (obs_d.size() !== exp_d.size()) begin
      n_mis++; $display("FAIL b2b_count: got %0d chunks, expected %0d", obs_d.size(), exp_d.size());
    end
    for (int k = 0; k < exp_d.size() && k < obs_d.size(); k++) begin
      n_cmp++;
      if ({obs_d[k], obs_pa[k], obs_pl[k], obs_bc[k]} !== {exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]}) begin
        n_mis++;
        $display("FAIL b2b_chunk[%0d]: got %h/%h/%h/%b, expected %h/%h/%h/%b", k, obs_d[k], obs_pa[k],
                 obs_pl[k], obs_bc[k], exp_d[k], exp_pa[k], exp_pl[k], exp_bc[k]);
      end
    end
    n_cmp++;
    if (ovf !== 1'b0) begin n_mis++; $display("FAIL b2b_overflow: got %b, expected 0", ovf); end
  endtask

  initial begin
    test_reset();
    test_all_dummy();
    test_single_block();
    test_backpressure();
    test_random_paths();
    test_overflow();
    test_reset_mid_path();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
